// File: rtl/addr_mode_seq_pkg.sv
// Shared definitions for the effective-address sequencer:
//   - AM_* addressing-mode codes as driven by the decode FSM
//   - ams_state_t state encoding of the sequencer
//   - small helpers for mode classification
package addr_mode_seq_pkg;

  localparam int AMS_DATA_W = 8;

  localparam logic [2:0] AM_IMM  = 3'd0;
  localparam logic [2:0] AM_ZP   = 3'd1;
  localparam logic [2:0] AM_ZPI  = 3'd2;
  localparam logic [2:0] AM_ABS  = 3'd3;
  localparam logic [2:0] AM_ABSI = 3'd4;
  localparam logic [2:0] AM_INDX = 3'd5;
  localparam logic [2:0] AM_INDY = 3'd6;

  typedef enum logic [2:0] {
    AMS_IDLE  = 3'd0,
    AMS_OPLO  = 3'd1,
    AMS_OPHI  = 3'd2,
    AMS_PTRLO = 3'd3,
    AMS_PTRHI = 3'd4,
    AMS_FIX   = 3'd5,
    AMS_DONE  = 3'd6
  } ams_state_t;

  // Unassigned mode codes complete like immediate mode.
  function automatic logic ams_is_imm(input logic [2:0] mode);
    return (mode == AM_IMM) || (mode == 3'd7);
  endfunction

  function automatic logic [1:0] ams_pc_adv(input logic [2:0] mode);
    return ((mode == AM_ABS) || (mode == AM_ABSI)) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/addr_mode_seq_page_add.sv
// Index adder for the effective-address sequencer: adds an index to a
// low address byte and reports the carry into the high byte.
// Ports:
//   i_a      base low byte
//   i_b      index value
//   o_sum    low byte of the sum
//   o_carry  carry out of the low byte (page crossing)
module addr_mode_seq_page_add #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/addr_mode_seq.sv
// Effective-address sequencer. Walks the operand and pointer reads of the
// indexed/indirect addressing modes on the memory bus and returns the final
// effective address, with 6502 page-cross fix-up timing and zero-page wrap.
// Optional feature macro: AMS_DUMMY_READ_EN -- when defined, the fix-up
// cycle performs a read at {uncorrected high byte, low sum} like the 6510;
// when undefined, the fix-up cycle holds the bus address with rd low.
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_start       request, sampled only while idle
//   i_mode        addressing mode (AM_* codes)
//   i_idx         index register value, stable while busy
//   i_is_store    write access: indexed-abs/INDY always take the fix-up cycle
//   i_pc          address of the first operand byte, stable while busy
//   i_di          read data for the address presented on o_ab
//   o_ab          registered bus address
//   o_rd          o_ab carries a real read
//   o_busy        sequencer owns the bus (through the done cycle)
//   o_done        one-cycle completion pulse
//   o_ea          effective address, held until the next completion
//   o_page_cross  index add carried into the high byte
//   o_pc_adv      operand bytes consumed (1 or 2)
module addr_mode_seq
  import addr_mode_seq_pkg::*;
#(
  parameter int                DATA_W  = AMS_DATA_W,
  parameter logic [DATA_W-1:0] ZP_PAGE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_mode,
  input  logic [DATA_W-1:0]     i_idx,
  input  logic                  i_is_store,
  input  logic [2*DATA_W-1:0]   i_pc,
  input  logic [DATA_W-1:0]     i_di,
  output logic [2*DATA_W-1:0]   o_ab,
  output logic                  o_rd,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2*DATA_W-1:0]   o_ea,
  output logic                  o_page_cross,
  output logic [1:0]            o_pc_adv
);

  localparam int                ADDR_W   = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  ams_state_t          r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_ab, w_ab_nx;
  logic                r_rd, w_rd_nx;
  logic [ADDR_W-1:0]   r_ea, r_tmp_ea, w_res_ea;
  logic                r_page_cross, r_tmp_pcross, w_res_pcross;
  logic [1:0]          r_pc_adv, w_res_adv;
  logic                w_res_ld, w_tmp_ld;
  logic [DATA_W-1:0]   r_lo;
  logic [2:0]          r_mode;
  logic                r_store;
  logic [DATA_W-1:0]   w_add_a, w_sum, w_hi;
  logic                w_carry;

  // In OPLO the operand byte is still on di; later adds use the captured byte.
  assign w_add_a = (r_state == AMS_OPLO) ? i_di : r_lo;

  addr_mode_seq_page_add #(.DATA_W(DATA_W)) u_page_add (
    .i_a     (w_add_a),
    .i_b     (i_idx),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // High byte corrected by the index carry, wrapping within DATA_W bits.
  assign w_hi = i_di + (w_carry ? DATA_ONE : '0);

  always_comb begin
    w_state_nx   = r_state;
    w_ab_nx      = r_ab;
    w_rd_nx      = 1'b0;
    w_res_ld     = 1'b0;
    w_res_ea     = r_tmp_ea;
    w_res_pcross = r_tmp_pcross;
    w_res_adv    = ams_pc_adv(r_mode);
    w_tmp_ld     = 1'b0;
    case (r_state)
      AMS_IDLE: begin
        if (i_start) begin
          w_ab_nx = i_pc;
          if (ams_is_imm(i_mode)) begin
            w_state_nx   = AMS_DONE;
            w_res_ld     = 1'b1;
            w_res_ea     = i_pc;
            w_res_pcross = 1'b0;
            w_res_adv    = 2'd1;
          end else begin
            w_state_nx = AMS_OPLO;
            w_rd_nx    = 1'b1;
          end
        end
      end
      AMS_OPLO: begin
        w_res_pcross = 1'b0;
        case (r_mode)
          AM_ZP: begin
            w_state_nx = AMS_DONE;
            w_res_ld   = 1'b1;
            w_res_ea   = {ZP_PAGE, i_di};
          end
          // Zero-page indexed never leaves the zero page: carry dropped.
          AM_ZPI: begin
            w_state_nx = AMS_DONE;
            w_res_ld   = 1'b1;
            w_res_ea   = {ZP_PAGE, w_sum};
          end
          AM_ABS, AM_ABSI: begin
            w_state_nx = AMS_OPHI;
            w_ab_nx    = i_pc + ADDR_ONE;
            w_rd_nx    = 1'b1;
          end
          AM_INDX: begin
            w_state_nx = AMS_PTRLO;
            w_ab_nx    = {ZP_PAGE, w_sum};
            w_rd_nx    = 1'b1;
          end
          AM_INDY: begin
            w_state_nx = AMS_PTRLO;
            w_ab_nx    = {ZP_PAGE, i_di};
            w_rd_nx    = 1'b1;
          end
          default: begin
            w_state_nx = AMS_DONE;
            w_res_ld   = 1'b1;
            w_res_ea   = i_pc;
          end
        endcase
      end
      // Pointer high byte comes from the next zero-page location, wrapping.
      AMS_PTRLO: begin
        w_state_nx = AMS_PTRHI;
        w_ab_nx    = {ZP_PAGE, r_ab[DATA_W-1:0] + DATA_ONE};
        w_rd_nx    = 1'b1;
      end
      AMS_OPHI, AMS_PTRHI: begin
        if ((r_mode == AM_ABSI) || (r_mode == AM_INDY)) begin
          w_res_ea     = {w_hi, w_sum};
          w_res_pcross = w_carry;
          if (w_carry || r_store) begin
            w_state_nx = AMS_FIX;
            w_tmp_ld   = 1'b1;
`ifdef AMS_DUMMY_READ_EN
            w_ab_nx    = {i_di, w_sum};
            w_rd_nx    = 1'b1;
`endif
          end else begin
            w_state_nx = AMS_DONE;
            w_res_ld   = 1'b1;
          end
        end else begin
          w_state_nx   = AMS_DONE;
          w_res_ld     = 1'b1;
          w_res_ea     = {i_di, r_lo};
          w_res_pcross = 1'b0;
        end
      end
      AMS_FIX: begin
        w_state_nx = AMS_DONE;
        w_res_ld   = 1'b1;
      end
      AMS_DONE: w_state_nx = AMS_IDLE;
      default:  w_state_nx = AMS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= AMS_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ab         <= '0;
      r_rd         <= 1'b0;
      r_ea         <= '0;
      r_page_cross <= 1'b0;
      r_pc_adv     <= 2'd0;
    end else begin
      r_ab <= w_ab_nx;
      r_rd <= w_rd_nx;
      if (w_res_ld) begin
        r_ea         <= w_res_ea;
        r_page_cross <= w_res_pcross;
        r_pc_adv     <= w_res_adv;
      end
    end
  end

  // Working registers: only meaningful inside a sequence, so no reset.
  always_ff @(posedge i_clk) begin
    if ((r_state == AMS_OPLO) || (r_state == AMS_PTRLO)) begin
      r_lo <= i_di;
    end
    if ((r_state == AMS_IDLE) && i_start) begin
      r_mode  <= i_mode;
      r_store <= i_is_store;
    end
    if (w_tmp_ld) begin
      r_tmp_ea     <= w_res_ea;
      r_tmp_pcross <= w_res_pcross;
    end
  end

  assign o_ab         = r_ab;
  assign o_rd         = r_rd;
  assign o_busy       = (r_state != AMS_IDLE);
  assign o_done       = (r_state == AMS_DONE);
  assign o_ea         = r_ea;
  assign o_page_cross = r_page_cross;
  assign o_pc_adv     = r_pc_adv;

endmodule

// File: tb/tb_addr_mode_seq.sv
// Bench for addr_mode_seq: a flat 64 KiB memory answers bus reads, a
// behavioural model derives the expected address sequence, latency and
// result of each transaction, and a negedge monitor compares every cycle.
module tb_addr_mode_seq;
  import addr_mode_seq_pkg::*;

`ifdef AMS_DUMMY_READ_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  idx = 8'd0;
  logic        st_in = 1'b0;
  logic [15:0] pc = 16'd0;
  logic [7:0]  di;
  logic [15:0] ab, ea;
  logic        rd, busy, done, pcross;
  logic [1:0]  pc_adv;

  logic [7:0]  mem [0:65535];
  assign di = mem[ab];

  always #5 clk = ~clk;

  addr_mode_seq dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_start      (start),
    .i_mode       (mode),
    .i_idx        (idx),
    .i_is_store   (st_in),
    .i_pc         (pc),
    .i_di         (di),
    .o_ab         (ab),
    .o_rd         (rd),
    .o_busy       (busy),
    .o_done       (done),
    .o_ea         (ea),
    .o_page_cross (pcross),
    .o_pc_adv     (pc_adv)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected transaction, written by the driver, read by the monitor.
  logic [15:0] e_ea, e_dummy, e_ab_done;
  logic [15:0] e_addr [3];
  logic        e_pcr, e_fix;
  logic [1:0]  e_adv;
  int          e_lat, e_nrd;

  task automatic model(input logic [2:0] m, input logic [15:0] p, input logic [7:0] ix,
                       input logic st);
    logic [15:0] p1, base;
    logic [16:0] full;
    logic [7:0]  zp;
    p1 = p + 16'd1;
    base = 16'd0;
    e_addr[0] = p; e_addr[1] = 16'd0; e_addr[2] = 16'd0;
    e_pcr = 1'b0; e_fix = 1'b0; e_dummy = 16'd0; e_adv = 2'd1;
    e_nrd = 0; e_ea = p;
    case (m)
      AM_ZP:   begin e_ea = {8'h00, mem[p]}; e_nrd = 1; end
      AM_ZPI:  begin zp = mem[p] + ix; e_ea = {8'h00, zp}; e_nrd = 1; end
      AM_ABS:  begin e_addr[1] = p1; e_ea = {mem[p1], mem[p]}; e_nrd = 2; e_adv = 2'd2; end
      AM_ABSI: begin e_addr[1] = p1; base = {mem[p1], mem[p]}; e_nrd = 2; e_adv = 2'd2; end
      AM_INDX, AM_INDY: begin
        zp = (m == AM_INDX) ? mem[p] + ix : mem[p];
        e_addr[1] = {8'h00, zp};
        zp = zp + 8'd1;
        e_addr[2] = {8'h00, zp};
        base = {mem[e_addr[2]], mem[e_addr[1]]};
        e_ea = base;
        e_nrd = 3;
      end
      default: ;
    endcase
    if (m == AM_ABSI || m == AM_INDY) begin
      full    = {1'b0, base} + {9'd0, ix};
      e_ea    = full[15:0];
      e_pcr   = (full[15:8] != base[15:8]);
      e_fix   = e_pcr || st;
      e_dummy = {base[15:8], full[7:0]};
    end
    e_lat = (e_nrd == 0) ? 1 : e_nrd + 1 + int'(e_fix);
    if (e_nrd == 0)          e_ab_done = p;
    else if (e_fix && DUMMY) e_ab_done = e_dummy;
    else                     e_ab_done = e_addr[e_nrd-1];
  endtask

  bit txn_active = 1'b0;
  int cyc = 0;
  bit seen = 1'b0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      seen = 1'b0;
    end else if (!txn_active || seen) begin
      if (!txn_active) begin cyc = 0; seen = 1'b0; end
      chk("idle_done", done, 1'b0);
      chk("idle_rd", rd, 1'b0);
    end else begin
      cyc++;
      chk("busy", busy, 1'b1);
      if (cyc == e_lat) begin
        chk("done", done, 1'b1);
        chk("rd_done", rd, 1'b0);
        chk("ab_done", ab, e_ab_done);
        if (done) begin
          chk("ea", ea, e_ea);
          chk("page_cross", pcross, e_pcr);
          chk("pc_adv", pc_adv, e_adv);
        end
      end else if (e_fix && cyc == e_lat - 1) begin
        chk("fix_done", done, 1'b0);
        chk("fix_rd", rd, DUMMY);
        chk("fix_ab", ab, DUMMY ? e_dummy : e_addr[e_nrd-1]);
      end else if (cyc < e_lat) begin
        chk("early_done", done, 1'b0);
        chk("read_rd", rd, 1'b1);
        chk("read_ab", ab, e_addr[cyc-1]);
      end
      if (done) begin
        seen = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic run_txn(input logic [2:0] m, input logic [15:0] p, input logic [7:0] ix,
                         input logic st, input bit dup);
    int waited;
    int base;
    model(m, p, ix, st);
    @(negedge clk); #1;
    mode = m; pc = p; idx = ix; st_in = st;
    start = 1'b1; txn_active = 1'b1; base = done_cnt;
    @(negedge clk); #2; waited = 1;
    if (dup) begin @(negedge clk); #2; waited++; end
    start = 1'b0;
    while (done_cnt == base && waited < 16) begin
      @(negedge clk); #2; waited++;
    end
    if (done_cnt == base) begin
      n_chk++;
      $display("FAIL timeout: mode %0d no done after %0d cycles, expected %0d", m, waited, e_lat);
    end
    txn_active = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_ab", ab, 16'h0000);
    chk("rst_rd", rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ea", ea, 16'h0000);
    chk("rst_pcross", pcross, 1'b0);
    chk("rst_pc_adv", pc_adv, 2'd0);
    #1 rst_n = 1'b1;

    // ZPI wrap inside the zero page
    mem[16'h0200] = 8'hF0;
    model(AM_ZPI, 16'h0200, 8'h20, 1'b0);
    chk("pin_zpi_ea", e_ea, 16'h0010);
    chk("pin_zpi_lat", e_lat, 2);
    run_txn(AM_ZPI, 16'h0200, 8'h20, 1'b0, 1'b0);

    // ABSI page cross on a read
    mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
    model(AM_ABSI, 16'h0300, 8'h01, 1'b0);
    chk("pin_absi_ea", e_ea, 16'h1300);
    chk("pin_absi_pcr", e_pcr, 1'b1);
    chk("pin_absi_lat", e_lat, 4);
    run_txn(AM_ABSI, 16'h0300, 8'h01, 1'b0, 1'b0);

    // ABSI store without a cross still takes the fix-up cycle
    mem[16'h0400] = 8'h10; mem[16'h0401] = 8'h12;
    model(AM_ABSI, 16'h0400, 8'h05, 1'b1);
    chk("pin_absis_ea", e_ea, 16'h1215);
    chk("pin_absis_lat", e_lat, 4);
    run_txn(AM_ABSI, 16'h0400, 8'h05, 1'b1, 1'b0);

    // INDX pointer wrapping from 0xFF to 0x00
    mem[16'h0500] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
    model(AM_INDX, 16'h0500, 8'h01, 1'b0);
    chk("pin_indx_ea", e_ea, 16'h1234);
    chk("pin_indx_lat", e_lat, 4);
    run_txn(AM_INDX, 16'h0500, 8'h01, 1'b0, 1'b0);

    // INDY with page cross
    mem[16'h0600] = 8'h40; mem[16'h0040] = 8'h80; mem[16'h0041] = 8'h20;
    model(AM_INDY, 16'h0600, 8'h90, 1'b0);
    chk("pin_indy_ea", e_ea, 16'h2110);
    chk("pin_indy_lat", e_lat, 5);
    chk("pin_indy_dummy", e_dummy, 16'h2010);
    run_txn(AM_INDY, 16'h0600, 8'h90, 1'b0, 1'b0);

    // ABS operand high byte wraps to address 0
    run_txn(AM_ABS, 16'hFFFF, 8'h00, 1'b0, 1'b0);
    run_txn(AM_IMM, 16'h1234, 8'h00, 1'b0, 1'b1);
    run_txn(3'd7, 16'hBEEF, 8'h00, 1'b0, 1'b0);

    // Reset during PTRLO aborts the sequence
    model(AM_INDY, 16'h0600, 8'h90, 1'b0);
    @(negedge clk); #1;
    mode = AM_INDY; pc = 16'h0600; idx = 8'h90; st_in = 1'b0;
    start = 1'b1; txn_active = 1'b1;
    @(negedge clk); #2; start = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0; txn_active = 1'b0;
    #1;
    chk("abort_ab", ab, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rd", rd, 1'b0);
    chk("abort_ea", ea, 16'h0000);
    chk("abort_pcross", pcross, 1'b0);
    chk("abort_pc_adv", pc_adv, 2'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_txn(AM_INDY, 16'h0600, 8'h90, 1'b0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      logic [2:0]  m;
      logic [15:0] p;
      logic [7:0]  ix;
      m  = 3'($urandom_range(0, 7));
      p  = 16'($urandom);
      ix = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mem[p] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'hFE;
      run_txn(m, p, ix, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
